// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack bus and decode valid/ready handshake
// shared by fetch_ctrl and its memory/decode neighbours.
interface fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        id_ready;

   modport master (
      output imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc_plus4,
      input  imem_ack, imem_rdata, imem_err, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc_plus4,
      output imem_ack, imem_rdata, imem_err, id_ready
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs req/ack to instruction
// memory, hands words to decode, squashes stale fetches on redirect, reports faults.
module fetch_ctrl #(
   parameter logic [31:0] INITAL_ADDR = 32'h9fc00000,
   parameter int          TIMEOUT     = 255
) (
   input  logic        clk,
   input  logic        rest_n,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   fetch_ctrl_if.master bus,
   output logic        fetch_fault,
   output logic [31:0] fault_addr
);
   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   // DRAIN: misaligned redirect seen while a request is outstanding; the fault
   // is already reported but the stale ack must still be absorbed.
   typedef enum logic [2:0] {IDLE, REQ, HOLD, SQUASH, DRAIN, FAULT} state_t;

   state_t      state_reg, state_next;
   logic [31:0] fetch_pc_reg, fetch_pc_next;
   logic [31:0] pending_reg, pending_next;
   logic [31:0] if_inst_reg, if_inst_next;
   logic [31:0] if_pc_reg, if_pc_next;
   logic        if_valid_reg, if_valid_next;
   logic        fault_reg, fault_next;
   logic [31:0] fault_addr_reg, fault_addr_next;
   logic [15:0] cnt_reg, cnt_next;

   logic req_on, mis_redirect, ali_redirect, timeout_hit;

   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n) begin
         state_reg      <= IDLE;
         fetch_pc_reg   <= INITAL_ADDR;
         pending_reg    <= 32'h0;
         if_inst_reg    <= 32'h0;
         if_pc_reg      <= INITAL_ADDR;
         if_valid_reg   <= 1'b0;
         fault_reg      <= 1'b0;
         fault_addr_reg <= 32'h0;
         cnt_reg        <= 16'h0;
      end else begin
         state_reg      <= state_next;
         fetch_pc_reg   <= fetch_pc_next;
         pending_reg    <= pending_next;
         if_inst_reg    <= if_inst_next;
         if_pc_reg      <= if_pc_next;
         if_valid_reg   <= if_valid_next;
         fault_reg      <= fault_next;
         fault_addr_reg <= fault_addr_next;
         cnt_reg        <= cnt_next;
      end
   end

   // While squashing or draining, fetch_pc still holds the stale request address.
   assign req_on       = (state_reg == REQ) || (state_reg == SQUASH) || (state_reg == DRAIN);
   assign mis_redirect = redirect && (redirect_addr[1:0] != 2'b00);
   assign ali_redirect = redirect && (redirect_addr[1:0] == 2'b00);
   assign timeout_hit  = (TIMEOUT_CNT != 16'h0) && req_on && !bus.imem_ack &&
                         ((cnt_reg + 16'h1) == TIMEOUT_CNT);

   always_comb begin
      state_next      = state_reg;
      fetch_pc_next   = fetch_pc_reg;
      pending_next    = pending_reg;
      if_inst_next    = if_inst_reg;
      if_pc_next      = if_pc_reg;
      if_valid_next   = if_valid_reg;
      fault_next      = fault_reg;
      fault_addr_next = fault_addr_reg;
      cnt_next        = (req_on && !bus.imem_ack) ? cnt_reg + 16'h1 : cnt_reg;

      if (mis_redirect) begin
         if_valid_next   = 1'b0;
         fault_next      = 1'b1;
         fault_addr_next = redirect_addr;
         state_next      = (req_on && !bus.imem_ack) ? DRAIN : FAULT;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (ali_redirect) fetch_pc_next = redirect_addr;
               cnt_next   = 16'h0;
               state_next = REQ;
            end
            REQ: begin
               if (ali_redirect) begin
                  cnt_next = 16'h0;
                  if (bus.imem_ack) begin
                     fetch_pc_next = redirect_addr;
                  end else begin
                     pending_next = redirect_addr;
                     state_next   = SQUASH;
                  end
               end else if (bus.imem_ack) begin
                  if (bus.imem_err) begin
                     fault_next      = 1'b1;
                     fault_addr_next = fetch_pc_reg;
                     state_next      = FAULT;
                  end else begin
                     if_inst_next  = bus.imem_rdata;
                     if_pc_next    = fetch_pc_reg;
                     if_valid_next = 1'b1;
                     fetch_pc_next = fetch_pc_reg + 32'd4;
                     state_next    = HOLD;
                  end
               end else if (timeout_hit) begin
                  fault_next      = 1'b1;
                  fault_addr_next = fetch_pc_reg;
                  state_next      = FAULT;
               end
            end
            HOLD: begin
               if (ali_redirect || bus.id_ready) begin
                  if (ali_redirect) fetch_pc_next = redirect_addr;
                  if_valid_next = 1'b0;
                  cnt_next      = 16'h0;
                  state_next    = REQ;
               end
            end
            SQUASH, DRAIN: begin
               if (ali_redirect) begin
                  fault_next = 1'b0;
                  if (bus.imem_ack) begin
                     fetch_pc_next = redirect_addr;
                     cnt_next      = 16'h0;
                     state_next    = REQ;
                  end else begin
                     pending_next = redirect_addr;
                     if (state_reg == DRAIN) cnt_next = 16'h0;
                     state_next   = SQUASH;
                  end
               end else if (bus.imem_ack && state_reg == SQUASH) begin
                  fetch_pc_next = pending_reg;
                  cnt_next      = 16'h0;
                  state_next    = REQ;
               end else if (bus.imem_ack || timeout_hit) begin
                  if (state_reg == SQUASH) fault_addr_next = fetch_pc_reg;
                  fault_next = 1'b1;
                  state_next = FAULT;
               end
            end
            FAULT: begin
               if (ali_redirect) begin
                  fetch_pc_next = redirect_addr;
                  fault_next    = 1'b0;
                  cnt_next      = 16'h0;
                  state_next    = REQ;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign bus.imem_req    = req_on;
   assign bus.imem_addr   = req_on ? fetch_pc_reg : 32'h0;
   assign bus.if_valid    = if_valid_reg;
   assign bus.if_inst     = if_inst_reg;
   assign bus.if_pc       = if_pc_reg;
   assign bus.if_pc_plus4 = if_pc_reg + 32'd4;
   assign fetch_fault     = fault_reg;
   assign fault_addr      = fault_addr_reg;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory and decode are driven cycle by cycle
// and every observation is compared against hand-computed values.
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rest_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_addr = 32'h0;
   logic        fetch_fault;
   logic [31:0] fault_addr;
   int          checks = 0;
   int          errors = 0;

   fetch_ctrl_if bus ();

   fetch_ctrl #(.INITAL_ADDR(32'h9fc00000), .TIMEOUT(4)) dut (
      .clk           (clk),
      .rest_n        (rest_n),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .bus           (bus.master),
      .fetch_fault   (fetch_fault),
      .fault_addr    (fault_addr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   // One-cycle ack pulse with data/err, applied to the current state.
   task automatic ack(input logic [31:0] data, input logic err);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = data;
      bus.imem_err   = err;
      step();
      bus.imem_ack   = 1'b0;
      bus.imem_err   = 1'b0;
   endtask

   task automatic redir(input logic [31:0] addr);
      redirect      = 1'b1;
      redirect_addr = addr;
      step();
      redirect      = 1'b0;
   endtask

   task automatic accept();
      bus.id_ready = 1'b1;
      step();
      bus.id_ready = 1'b0;
   endtask

   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.imem_err   = 1'b0;
      bus.id_ready   = 1'b0;

      // reset state
      step(); step();
      chk("rst_req",    {31'h0, bus.imem_req},  32'h0);
      chk("rst_addr",   bus.imem_addr,          32'h0);
      chk("rst_valid",  {31'h0, bus.if_valid},  32'h0);
      chk("rst_inst",   bus.if_inst,            32'h0);
      chk("rst_pc",     bus.if_pc,              32'h9fc00000);
      chk("rst_pc4",    bus.if_pc_plus4,        32'h9fc00004);
      chk("rst_fault",  {31'h0, fetch_fault},   32'h0);
      chk("rst_faddr",  fault_addr,             32'h0);

      // first fetch after one idle cycle, ack one cycle after req
      rest_n = 1'b1;
      step();
      chk("f0_req",     {31'h0, bus.imem_req},  32'h1);
      chk("f0_addr",    bus.imem_addr,          32'h9fc00000);
      step();
      ack(32'h11111111, 1'b0);
      chk("f0_valid",   {31'h0, bus.if_valid},  32'h1);
      chk("f0_inst",    bus.if_inst,            32'h11111111);
      chk("f0_pc",      bus.if_pc,              32'h9fc00000);
      chk("f0_pc4",     bus.if_pc_plus4,        32'h9fc00004);
      chk("f0_hreq",    {31'h0, bus.imem_req},  32'h0);
      accept();
      chk("f1_valid",   {31'h0, bus.if_valid},  32'h0);
      chk("f1_addr",    bus.imem_addr,          32'h9fc00004);
      step();
      ack(32'h22222222, 1'b0);
      chk("f1_inst",    bus.if_inst,            32'h22222222);
      chk("f1_pc",      bus.if_pc,              32'h9fc00004);

      // decode stalls for five cycles
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", {31'h0, bus.if_valid}, 32'h1);
         chk("stall_inst",  bus.if_inst,           32'h22222222);
         chk("stall_req",   {31'h0, bus.imem_req}, 32'h0);
      end
      accept();
      chk("f2_addr",    bus.imem_addr,          32'h9fc00008);

      // redirect while request outstanding; stale data arrives later
      redir(32'h80000100);
      chk("sq_addr",    bus.imem_addr,          32'h9fc00008);
      chk("sq_req",     {31'h0, bus.imem_req},  32'h1);
      step();
      step();
      chk("sq_valid",   {31'h0, bus.if_valid},  32'h0);
      ack(32'hdeadbeef, 1'b0);
      chk("sq_valid2",  {31'h0, bus.if_valid},  32'h0);
      chk("sq_newaddr", bus.imem_addr,          32'h80000100);
      step();
      ack(32'h33333333, 1'b0);
      chk("sq_inst",    bus.if_inst,            32'h33333333);
      chk("sq_pc",      bus.if_pc,              32'h80000100);

      // second redirect while squashing overrides the pending target
      accept();
      redir(32'h80000180);
      redir(32'h80000200);
      chk("sq2_addr",   bus.imem_addr,          32'h80000104);
      ack(32'hbad0bad0, 1'b0);
      chk("sq2_new",    bus.imem_addr,          32'h80000200);
      ack(32'h44444444, 1'b0);
      chk("sq2_pc",     bus.if_pc,              32'h80000200);
      chk("sq2_inst",   bus.if_inst,            32'h44444444);

      // redirect coincident with ack drops the data
      accept();
      redirect = 1'b1;
      redirect_addr = 32'h80000300;
      ack(32'hcafef00d, 1'b0);
      redirect = 1'b0;
      chk("co_valid",   {31'h0, bus.if_valid},  32'h0);
      chk("co_addr",    bus.imem_addr,          32'h80000300);
      step();
      ack(32'h55555555, 1'b0);
      chk("co_pc",      bus.if_pc,              32'h80000300);

      // misaligned redirect, then recovery by aligned redirect
      redir(32'h80000102);
      chk("mis_fault",  {31'h0, fetch_fault},   32'h1);
      chk("mis_faddr",  fault_addr,             32'h80000102);
      chk("mis_req",    {31'h0, bus.imem_req},  32'h0);
      chk("mis_valid",  {31'h0, bus.if_valid},  32'h0);
      step();
      chk("mis_req2",   {31'h0, bus.imem_req},  32'h0);
      redir(32'h80000000);
      chk("rec_fault",  {31'h0, fetch_fault},   32'h0);
      chk("rec_addr",   bus.imem_addr,          32'h80000000);
      ack(32'h66666666, 1'b0);
      chk("rec_pc",     bus.if_pc,              32'h80000000);

      // bus error
      redir(32'h9fc00004);
      ack(32'h0, 1'b1);
      chk("err_fault",  {31'h0, fetch_fault},   32'h1);
      chk("err_faddr",  fault_addr,             32'h9fc00004);
      chk("err_valid",  {31'h0, bus.if_valid},  32'h0);

      // timeout after four unacknowledged cycles, then a late ack
      redir(32'h90000000);
      chk("to_fclr",    {31'h0, fetch_fault},   32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("to_wait",    {31'h0, bus.imem_req}, 32'h1);
      end
      step();
      chk("to_fault",   {31'h0, fetch_fault},   32'h1);
      chk("to_faddr",   fault_addr,             32'h90000000);
      chk("to_req",     {31'h0, bus.imem_req},  32'h0);
      ack(32'h12345678, 1'b0);
      chk("late_valid", {31'h0, bus.if_valid},  32'h0);
      chk("late_fault", {31'h0, fetch_fault},   32'h1);
      chk("late_req",   {31'h0, bus.imem_req},  32'h0);

      // misaligned redirect during an outstanding request faults at once
      redir(32'h80000500);
      redir(32'h80000506);
      chk("dr_fault",   {31'h0, fetch_fault},   32'h1);
      chk("dr_faddr",   fault_addr,             32'h80000506);
      ack(32'h0badf00d, 1'b0);
      chk("dr_req",     {31'h0, bus.imem_req},  32'h0);
      chk("dr_valid",   {31'h0, bus.if_valid},  32'h0);

      // asynchronous reset in the middle of a request
      redir(32'h80000400);
      chk("ar_req1",    {31'h0, bus.imem_req},  32'h1);
      #2 rest_n = 1'b0;
      #1;
      chk("ar_req0",    {31'h0, bus.imem_req},  32'h0);
      chk("ar_fault",   {31'h0, fetch_fault},   32'h0);
      step();
      rest_n = 1'b1;
      step();
      chk("ar_addr",    bus.imem_addr,          32'h9fc00000);

      // address wrap
      ack(32'h77777777, 1'b0);
      redir(32'hfffffffc);
      chk("wr_addr",    bus.imem_addr,          32'hfffffffc);
      ack(32'h88888888, 1'b0);
      chk("wr_pc",      bus.if_pc,              32'hfffffffc);
      chk("wr_pc4",     bus.if_pc_plus4,        32'h00000000);
      accept();
      chk("wr_next",    bus.imem_addr,          32'h00000000);
      chk("wr_fault",   {31'h0, fetch_fault},   32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
